// File: rtl/alu_pkg.sv
// Shared types for the ALU result path: opcodes, flag indices and
// the tagged result entry queued behind the ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_MUL = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_XOR = 3'b101,
        OP_NOT = 3'b110
    } alu_op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef struct packed {
        logic [31:0] result;
        logic [2:0]  opcode;
        logic [3:0]  flags;
    } alu_entry_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flags {V, C, N, Z} for one ALU result.
// Opcode 111 has no enum member and only reports Z.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [2:0]  opcode,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [31:0] result,
    output logic [3:0]  flags
);

    always_comb begin
        flags = '0;
        flags[FLAG_Z] = (result == 32'd0);
        case (opcode)
            OP_ADD: begin
                flags[FLAG_N] = result[15];
                flags[FLAG_C] = result[16];
                flags[FLAG_V] = (a[15] == b[15]) && (result[15] != a[15]);
            end
            OP_SUB: begin
                flags[FLAG_N] = result[15];
                flags[FLAG_C] = (a < b);
                flags[FLAG_V] = (a[15] != b[15]) && (result[15] != a[15]);
            end
            OP_MUL: begin
                flags[FLAG_N] = result[31];
                flags[FLAG_C] = |result[31:16];
            end
            OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                flags[FLAG_N] = result[15];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_result_fifo.sv
// Tags each ALU result with opcode and flags and queues it in a
// small valid/ready FIFO with a sticky signed-overflow indicator.
module alu_result_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RES_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_opcode,
    input  logic [15:0]              in_a,
    input  logic [15:0]              in_b,
    input  logic [RES_W-1:0]         in_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RES_W-1:0]         out_result,
    output logic [2:0]               out_opcode,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_sticky,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    alu_entry_t     mem [DEPTH];
    alu_entry_t     head;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [3:0]     flags;
    logic           full;
    logic           push;
    logic           pop;

    alu_flag_gen u_flag_gen (
        .opcode (in_opcode),
        .a      (in_a),
        .b      (in_b),
        .result (in_result),
        .flags  (flags)
    );

    assign full      = (count == CW'(DEPTH));
    assign in_ready  = !full && !rst;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset; count gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{result: in_result, opcode: in_opcode, flags: flags};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (push && flags[FLAG_V]) ovf_sticky <= 1'b1;
            else if (ovf_clr)          ovf_sticky <= 1'b0;
        end
    end

    always_comb begin
        head = '0;
        if (out_valid) head = mem[rd_ptr];
    end

    assign out_result = head.result;
    assign out_opcode = head.opcode;
    assign out_flags  = head.flags;

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed self-checking bench for alu_result_fifo (DEPTH=4).
module tb_alu_result_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_opcode;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [31:0] in_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_opcode;
    logic [3:0]  out_flags;
    logic [2:0]  count;
    logic        ovf_sticky;
    logic        ovf_clr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_result_fifo #(.DEPTH(4), .RES_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_result  (in_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_opcode (out_opcode),
        .out_flags  (out_flags),
        .count      (count),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [31:0] res);
        in_opcode = op;
        in_a      = a;
        in_b      = b;
        in_result = res;
        in_valid  = 1'b1;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Push one vector, check head result/opcode/flags, then drain it.
    task automatic vec(input string tag, input logic [2:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] res, input logic [3:0] exp_flags);
        push(op, a, b, res);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_res"}, out_result, res);
        check({tag, "_op"}, 32'(out_opcode), 32'(op));
        check({tag, "_flags"}, 32'(out_flags), 32'(exp_flags));
        pop();
        check({tag, "_empty"}, 32'(count), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_opcode = '0;
        in_a = '0;
        in_b = '0;
        in_result = '0;
        out_ready = 1'b0;
        ovf_clr = 1'b0;
        step();
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_res", out_result, 32'd0);
        check("rst_sticky", 32'(ovf_sticky), 32'd0);
        rst = 1'b0;
        #1;
        check("rel_ready", 32'(in_ready), 32'd1);

        // Flag vectors: {V,C,N,Z}
        vec("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 32'h0000_8000, 4'b1010);
        check("sticky_set", 32'(ovf_sticky), 32'd1);
        vec("sub_brw", 3'b010, 16'h0003, 16'h0005, 32'hFFFF_FFFE, 4'b0110);
        vec("mul_c", 3'b001, 16'h0100, 16'h0100, 32'h0001_0000, 4'b0100);
        vec("add_c", 3'b000, 16'hFFFF, 16'h0001, 32'h0001_0000, 4'b0100);
        vec("and_z", 3'b011, 16'h00F0, 16'h000F, 32'h0000_0000, 4'b0001);
        vec("op7_z", 3'b111, 16'h1234, 16'h5678, 32'h0000_0000, 4'b0001);
        vec("op7_nz", 3'b111, 16'h8000, 16'h8000, 32'h8001_8001, 4'b0000);
        vec("sub_v", 3'b010, 16'h8000, 16'h0001, 32'h0000_7FFF, 4'b1000);

        // Fill to full with consumer stalled
        in_opcode = 3'b100;
        in_a = '0;
        in_b = '0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_result = 32'h100 + 32'(i);
            step();
        end
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        in_result = 32'h999;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_head", out_result, 32'h100);
            check("stall_count", 32'(count), 32'd4);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", out_result, 32'h100 + 32'(i));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty", 32'(out_valid), 32'd0);

        // Streaming across pointer wrap
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_result = 32'h200 + 32'(i);
            step();
            check("stream_head", out_result, 32'h200 + 32'(i));
            check("stream_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        check("stream_end", 32'(count), 32'd0);

        // Asynchronous reset mid-stream
        push(3'b000, 16'h7FFF, 16'h0001, 32'h0000_8000);
        push(3'b100, 16'h0000, 16'h0000, 32'h0000_0301);
        push(3'b100, 16'h0000, 16'h0000, 32'h0000_0302);
        check("pre_rst_count", 32'(count), 32'd3);
        check("pre_rst_sticky", 32'(ovf_sticky), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_res", out_result, 32'd0);
        check("arst_op", 32'(out_opcode), 32'd0);
        check("arst_flags", 32'(out_flags), 32'd0);
        check("arst_sticky", 32'(ovf_sticky), 32'd0);
        check("arst_ready", 32'(in_ready), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check("rel2_ready", 32'(in_ready), 32'd1);
        vec("post_rst", 3'b000, 16'h0050, 16'h0005, 32'h0000_0055, 4'b0000);

        // Sticky set beats clear in the same cycle
        ovf_clr = 1'b1;
        push(3'b000, 16'h7FFF, 16'h7FFF, 32'h0000_FFFE);
        check("set_wins", 32'(ovf_sticky), 32'd1);
        step();
        ovf_clr = 1'b0;
        check("clr_alone", 32'(ovf_sticky), 32'd0);
        pop();
        check("final_empty", 32'(count), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
